// File: rtl/patp_sequencer.sv
// patp_sequencer: fetch/decode/execute sequencer for the PATP accumulator
// machine. Owns the program counter, instruction register and the memory
// handshake, and emits one-cycle one-hot execute strobes to the datapath.
module patp_sequencer #(
  parameter int OPCODE_W = 3,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_ready,
  input  logic [OPCODE_W+ADDR_W-1:0]   mem_rdata,
  input  logic                         acc_zero,
  output logic [2**OPCODE_W-1:0]       op_strobe,
  output logic [ADDR_W-1:0]            operand,
  output logic [ADDR_W-1:0]            pc,
  output logic                         busy,
  output logic [CNT_W-1:0]             retired
);

  localparam int INSN_W = OPCODE_W + ADDR_W;

  // Opcodes that need special handling; everything else is a plain EXEC.
  localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_JUMP  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_BUZ   = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(7);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4
  } state_t;

  state_t                  state_r, state_s;
  logic [INSN_W-1:0]       ir_r, ir_s;
  logic [ADDR_W-1:0]       pc_r, pc_s, pc_done_s;
  logic [CNT_W-1:0]        retired_r, retired_s;
  logic [OPCODE_W-1:0]     ir_op_s;
  logic [ADDR_W-1:0]       ir_opnd_s;
  logic                    req_s, we_s, done_s;
  logic [ADDR_W-1:0]       addr_s;
  logic [2**OPCODE_W-1:0]  strobe_s;

  assign ir_op_s   = ir_r[INSN_W-1:ADDR_W];
  assign ir_opnd_s = ir_r[ADDR_W-1:0];

  // Branch resolution: the pc an instruction leaves behind when it completes.
  always_comb begin
    pc_done_s = pc_r + ADDR_W'(1);
    if (ir_op_s == OP_JUMP) begin
      pc_done_s = ir_opnd_s;
    end else if ((ir_op_s == OP_BUZ) && acc_zero) begin
      pc_done_s = ir_opnd_s;
    end else begin
      pc_done_s = pc_r + ADDR_W'(1);
    end
  end

  // Next-state, handshake and strobe decode; completion updates pc/retired.
  always_comb begin
    state_s   = state_r;
    ir_s      = ir_r;
    pc_s      = pc_r;
    retired_s = retired_r;
    req_s     = 1'b0;
    we_s      = 1'b0;
    addr_s    = '0;
    strobe_s  = '0;
    done_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (run) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        req_s  = 1'b1;
        addr_s = pc_r;
        if (mem_ready) begin
          ir_s    = mem_rdata;
          state_s = ST_DECODE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if ((ir_op_s == OP_ADD) || (ir_op_s == OP_LOAD) || (ir_op_s == OP_STORE)) begin
          state_s = ST_MEM;
        end else begin
          state_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        strobe_s[ir_op_s] = 1'b1;
        done_s            = 1'b1;
      end
      ST_MEM: begin
        req_s  = 1'b1;
        addr_s = ir_opnd_s;
        we_s   = (ir_op_s == OP_STORE);
        if (mem_ready) begin
          // Datapath captures read data / performs the write on this cycle.
          strobe_s[ir_op_s] = 1'b1;
          done_s            = 1'b1;
        end else begin
          state_s = ST_MEM;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // run is only looked at here and in IDLE, so an instruction never aborts.
    if (done_s) begin
      pc_s      = pc_done_s;
      retired_s = retired_r + CNT_W'(1);
      state_s   = run ? ST_FETCH : ST_IDLE;
    end else begin
      pc_s      = pc_r;
      retired_s = retired_r;
    end
  end

  // Architectural state; async reset also drops an in-flight request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      ir_r      <= '0;
      pc_r      <= '0;
      retired_r <= '0;
    end else begin
      state_r   <= state_s;
      ir_r      <= ir_s;
      pc_r      <= pc_s;
      retired_r <= retired_s;
    end
  end

  assign mem_req   = req_s;
  assign mem_we    = we_s;
  assign mem_addr  = addr_s;
  assign op_strobe = strobe_s;
  assign operand   = ir_opnd_s;
  assign pc        = pc_r;
  assign busy      = (state_r != ST_IDLE);
  assign retired   = retired_r;

endmodule
